freq_meas: RTL and testbench

- Downstream consumer of freq_del: measures the divided signal that freq_del produces, in cycles of the shared system clock.
- Reports period, high time and a measurement count on every rising edge of the input.
- Flags a stall when the input stops toggling.
- Used in bench and on silicon to self-check divider ratio and duty cycle.

---
 rtl/freq_pkg.sv | 15 +
 rtl/freq_meas_edge_det.sv | 21 ++
 rtl/freq_meas.sv | 92 +++++++++
 tb/tb_freq_meas.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and default sizing for the frequency divider / measurement stages.
// Benches for freq_del pick up the same defaults from here.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_MCNT_W  = 8;

endpackage

// File: rtl/freq_meas_edge_det.sv
// Registered-reference edge detector: rise/fall are combinational against the
// previous-cycle sample, so they are valid in the same cycle the input changes.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic sig_d
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sig_d <= 1'b0;
    else       sig_d <= sig_in;
  end

  assign rise = sig_in & ~sig_d;
  assign fall = ~sig_in & sig_d;

endmodule

// File: rtl/freq_meas.sv
// Measures period and high time of sig_in in clk cycles, counts measurements
// and flags a stall when no rising edge arrives within TIMEOUT cycles.
module freq_meas
  import freq_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int MCNT_W  = DEF_MCNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              stall,
  output logic [MCNT_W-1:0] meas_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic             rise;
  logic             unused_fall;
  logic             unused_sig_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  state_e           state;

  edge_det u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (unused_fall),
    .sig_d  (unused_sig_d)
  );

  // Counters reload to 1 on a rise because the rise cycle itself belongs to
  // the new period (and is high); they saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX)          per_cnt <= per_cnt + 1'b1;
      if (sig_in && hi_cnt != CNT_MAX) hi_cnt  <= hi_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stall     <= 1'b0;
      meas_cnt  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= MEAS;
        end
        MEAS: begin
          // A rise coinciding with the timeout is still a good measurement.
          if (rise) begin
            period    <= per_cnt;
            high_time <= hi_cnt;
            valid     <= 1'b1;
            meas_cnt  <= meas_cnt + 1'b1;
          end else if (per_cnt == TIMEOUT_V) begin
            stall <= 1'b1;
            state <= STALL;
          end
        end
        STALL: begin
          // The edge ending a stall has no valid reference, so it only re-arms.
          if (rise) begin
            stall <= 1'b0;
            state <= MEAS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas.sv
// Directed bench for freq_meas: one instance with TIMEOUT=20 for function and
// stall checks, one with CNT_W=4/TIMEOUT=15 for saturation behaviour.
module tb_freq_meas;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_in;

  logic [15:0] period_a, high_time_a;
  logic        valid_a, stall_a;
  logic [7:0]  meas_cnt_a;

  logic [3:0]  period_b, high_time_b;
  logic        valid_b, stall_b;
  logic [7:0]  meas_cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  freq_meas #(.CNT_W(16), .TIMEOUT(20), .MCNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period_a),
    .high_time (high_time_a),
    .valid     (valid_a),
    .stall     (stall_a),
    .meas_cnt  (meas_cnt_a)
  );

  freq_meas #(.CNT_W(4), .TIMEOUT(15), .MCNT_W(8)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period_b),
    .high_time (high_time_b),
    .valid     (valid_b),
    .stall     (stall_b),
    .meas_cnt  (meas_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one input value for one clock edge; outputs of that edge are
  // observable when this returns (on the following negedge).
  task automatic drive(input logic v);
    sig_in = v;
    @(negedge clk);
  endtask

  task automatic check_all(input string t, input bit sat, input logic ev, input logic es,
                           input int ep, input int eh, input int em);
    check({t, "_valid"},  32'(sat ? valid_b : valid_a), 32'(ev));
    check({t, "_stall"},  32'(sat ? stall_b : stall_a), 32'(es));
    check({t, "_period"}, sat ? 32'(period_b) : 32'(period_a), ep);
    check({t, "_high"},   sat ? 32'(high_time_b) : 32'(high_time_a), eh);
    check({t, "_mcnt"},   sat ? 32'(meas_cnt_b) : 32'(meas_cnt_a), em);
  endtask

  // One period of h high then l low cycles, starting from sig_in low.
  // Checks the outputs produced by the opening rise and that valid drops after.
  task automatic pulse_check(input bit sat, input int h, input int l, input logic ev,
                             input logic es, input int ep, input int eh, input int em);
    string t;
    t = $sformatf("%s_%0dh%0dl_m%0d", sat ? "sat" : "main", h, l, em);
    drive(1'b1);
    check_all(t, sat, ev, es, ep, eh, em);
    for (int i = 1; i < h + l; i++) begin
      drive(i < h);
      if (i == 1) check({t, "_vdrop"}, 32'(sat ? valid_b : valid_a), 32'd0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset_main", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    reset = 1'b0;

    // 7 high / 7 low: first rise is reference only
    pulse_check(1'b0, 7, 7, 1'b0, 1'b0, 0, 0, 0);
    pulse_check(1'b0, 7, 7, 1'b1, 1'b0, 14, 7, 1);
    pulse_check(1'b0, 7, 7, 1'b1, 1'b0, 14, 7, 2);
    pulse_check(1'b0, 7, 7, 1'b1, 1'b0, 14, 7, 3);

    // toggle every cycle
    pulse_check(1'b0, 1, 1, 1'b1, 1'b0, 14, 7, 4);
    pulse_check(1'b0, 1, 1, 1'b1, 1'b0, 2, 1, 5);
    pulse_check(1'b0, 1, 1, 1'b1, 1'b0, 2, 1, 6);
    pulse_check(1'b0, 1, 1, 1'b1, 1'b0, 2, 1, 7);

    // 3 high / 5 low, then switch to 6 high / 2 low
    pulse_check(1'b0, 3, 5, 1'b1, 1'b0, 2, 1, 8);
    pulse_check(1'b0, 3, 5, 1'b1, 1'b0, 8, 3, 9);
    pulse_check(1'b0, 3, 5, 1'b1, 1'b0, 8, 3, 10);
    pulse_check(1'b0, 6, 2, 1'b1, 1'b0, 8, 3, 11);
    pulse_check(1'b0, 6, 2, 1'b1, 1'b0, 8, 6, 12);

    // stall: single-cycle pulse then low; stall visible after the 20th cycle
    drive(1'b1);
    check_all("stall_rise", 1'b0, 1'b1, 1'b0, 8, 6, 13);
    for (int i = 1; i < 20; i++) drive(1'b0);
    check("stall_before", 32'(stall_a), 32'd0);
    drive(1'b0);
    check("stall_at", 32'(stall_a), 32'd1);
    check("stall_no_valid", 32'(valid_a), 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b0);
    check_all("stall_hold", 1'b0, 1'b0, 1'b1, 8, 6, 13);

    // recovery rise: no valid, values held; next rise measures normally
    pulse_check(1'b0, 4, 4, 1'b0, 1'b0, 8, 6, 13);
    pulse_check(1'b0, 4, 4, 1'b1, 1'b0, 8, 4, 14);

    // period equal to TIMEOUT: rise wins over stall
    pulse_check(1'b0, 10, 10, 1'b1, 1'b0, 8, 4, 15);
    pulse_check(1'b0, 1, 1, 1'b1, 1'b0, 20, 10, 16);

    // reset mid-period
    drive(1'b1);
    check_all("pre_reset", 1'b0, 1'b1, 1'b0, 2, 1, 17);
    drive(1'b1);
    drive(1'b1);
    reset = 1'b1;
    drive(1'b0);
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    reset = 1'b0;
    drive(1'b0);
    drive(1'b0);
    pulse_check(1'b0, 3, 3, 1'b0, 1'b0, 0, 0, 0);
    pulse_check(1'b0, 3, 3, 1'b1, 1'b0, 6, 3, 1);

    // saturation instance (CNT_W=4, TIMEOUT=15)
    reset = 1'b1;
    drive(1'b0);
    check_all("reset_sat", 1'b1, 1'b0, 1'b0, 0, 0, 0);
    reset = 1'b0;
    pulse_check(1'b1, 7, 7, 1'b0, 1'b0, 0, 0, 0);
    pulse_check(1'b1, 7, 7, 1'b1, 1'b0, 14, 7, 1);
    pulse_check(1'b1, 8, 7, 1'b1, 1'b0, 14, 7, 2);
    pulse_check(1'b1, 7, 7, 1'b1, 1'b0, 15, 8, 3);

    // stretch to a 27-cycle period: stall at 15, no wrapped value reported
    drive(1'b1);
    check_all("sat_stretch_rise", 1'b1, 1'b1, 1'b0, 14, 7, 4);
    for (int i = 1; i < 15; i++) drive(1'b1);
    check("sat_stall_before", 32'(stall_b), 32'd0);
    drive(1'b0);
    check("sat_stall_at", 32'(stall_b), 32'd1);
    for (int i = 0; i < 11; i++) drive(1'b0);
    pulse_check(1'b1, 7, 7, 1'b0, 1'b0, 14, 7, 4);
    pulse_check(1'b1, 7, 7, 1'b1, 1'b0, 14, 7, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
